// File: rtl/btn_cmd_filter.sv
// Push-button conditioner: per-channel 2-flop synchronizer, counter-based debounce FSM and a
// registered one-cycle press pulse. All logic runs on the pixel clock.
module btn_cmd_filter #(
    parameter int unsigned NUM_BTN         = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 251750,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] i_btn_raw,
    output logic [NUM_BTN-1:0] o_press_pulse,
    output logic [NUM_BTN-1:0] o_btn_level
);

    localparam int unsigned   CntW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StArming,
        StPressed,
        StDisarming
    } state_e;

    logic [NUM_BTN-1:0] pressed_raw;
    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;

    // Normalise polarity so that 1 always means "pressed" downstream.
    assign pressed_raw = i_btn_raw ^ {NUM_BTN{BTN_ACTIVE_LOW}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pressed_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        state_e          state_q, state_d;
        logic [CntW-1:0] cnt_q, cnt_d;
        logic            pulse_q, pulse_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pulse_q <= pulse_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pulse_d = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (sync2_q[i]) begin
                        state_d = StArming;
                        cnt_d   = CntOne;
                    end else begin
                        cnt_d = '0;
                    end
                end
                StArming: begin
                    // Any released sample throws away the accumulated count.
                    if (!sync2_q[i]) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d = StPressed;
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StPressed: begin
                    if (!sync2_q[i]) begin
                        state_d = StDisarming;
                        cnt_d   = CntOne;
                    end else begin
                        cnt_d = '0;
                    end
                end
                StDisarming: begin
                    if (sync2_q[i]) begin
                        state_d = StPressed;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end

        assign o_press_pulse[i] = pulse_q;
        assign o_btn_level[i]   = (state_q == StPressed) || (state_q == StDisarming);
    end

endmodule

// File: tb/tb_btn_cmd_filter.sv
// Directed bench for btn_cmd_filter with D=4, three active-low channels.
module tb_btn_cmd_filter;

    localparam int unsigned NumBtn = 3;
    localparam int unsigned Deb    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NumBtn-1:0] btn_raw;
    logic [NumBtn-1:0] press_pulse;
    logic [NumBtn-1:0] btn_level;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    btn_cmd_filter #(
        .NUM_BTN        (NumBtn),
        .DEBOUNCE_CYCLES(Deb),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_btn_raw    (btn_raw),
        .o_press_pulse(press_pulse),
        .o_btn_level  (btn_level)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge and settle, so samples are away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run n edges and count the edges after which any masked channel pulsed.
    task automatic tick_count(input int n, input logic [NumBtn-1:0] mask, output int pulses);
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if ((press_pulse & mask) != '0) pulses++;
        end
    endtask

    int pulses;

    initial begin
        // Reset with every button pressed.
        rst_n   = 1'b0;
        btn_raw = 3'b000;
        #3;
        check_eq("rst_level_async", btn_level, 3'b000);
        check_eq("rst_pulse_async", press_pulse, 3'b000);
        tick_count(3, 3'b111, pulses);
        check_eq("rst_pulse_held", pulses, 0);
        check_eq("rst_level_held", btn_level, 3'b000);

        rst_n = 1'b1;
        tick_count(5, 3'b111, pulses);
        check_eq("rst_rel_no_early_pulse", pulses, 0);
        check_eq("rst_rel_level_e4", btn_level, 3'b000);
        tick();
        check_eq("rst_rel_pulse_e5", press_pulse, 3'b111);
        check_eq("rst_rel_level_e5", btn_level, 3'b111);
        tick();
        check_eq("rst_rel_pulse_e6", press_pulse, 3'b000);
        check_eq("rst_rel_level_e6", btn_level, 3'b111);

        // Release all: level drops after edge 5, no release pulse.
        btn_raw = 3'b111;
        tick_count(5, 3'b111, pulses);
        check_eq("rel_all_level_e4", btn_level, 3'b111);
        tick();
        check_eq("rel_all_level_e5", btn_level, 3'b000);
        check_eq("rel_all_no_pulse", pulses + int'(press_pulse != '0), 0);

        // Clean press on ch0.
        btn_raw = 3'b110;
        tick_count(5, 3'b111, pulses);
        check_eq("ch0_no_early_pulse", pulses, 0);
        tick();
        check_eq("ch0_pulse_e5", press_pulse, 3'b001);
        check_eq("ch0_level_e5", btn_level, 3'b001);
        tick();
        check_eq("ch0_pulse_e6", press_pulse, 3'b000);
        check_eq("ch0_level_e6", btn_level, 3'b001);
        btn_raw = 3'b111;
        tick_count(6, 3'b111, pulses);
        check_eq("ch0_release_level", btn_level, 3'b000);
        check_eq("ch0_release_no_pulse", pulses, 0);

        // Bounce on ch1: P P P R P P P R, then hold.
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            btn_raw = ((k % 4) == 3) ? 3'b111 : 3'b101;
            tick();
            if (press_pulse != '0) pulses++;
            if (btn_level != '0) pulses++;
        end
        btn_raw = 3'b101;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (press_pulse != '0) pulses++;
            if (btn_level != '0) pulses++;
        end
        check_eq("bounce_no_activity", pulses, 0);
        tick();
        check_eq("bounce_hold_pulse_e5", press_pulse, 3'b010);
        check_eq("bounce_hold_level_e5", btn_level, 3'b010);
        btn_raw = 3'b111;
        tick_count(6, 3'b111, pulses);
        check_eq("bounce_release_level", btn_level, 3'b000);

        // Long hold on ch2, then release with a 2-cycle re-press glitch.
        btn_raw = 3'b011;
        tick_count(1000, 3'b100, pulses);
        check_eq("long_hold_one_pulse", pulses, 1);
        check_eq("long_hold_level", btn_level, 3'b100);
        pulses = 0;
        for (int k = 0; k < 9; k++) begin
            btn_raw = (k == 2 || k == 3) ? 3'b011 : 3'b111;
            tick();
            if (press_pulse != '0) pulses++;
            if (btn_level != 3'b100) pulses++;
        end
        check_eq("glitch_level_held_e0_e8", pulses, 0);
        tick();
        check_eq("glitch_level_drop_e9", btn_level, 3'b000);
        check_eq("glitch_no_pulse_e9", press_pulse, 3'b000);

        // ch0 and ch2 together.
        btn_raw = 3'b010;
        tick_count(5, 3'b111, pulses);
        check_eq("dual_no_early_pulse", pulses, 0);
        tick();
        check_eq("dual_pulse_e5", press_pulse, 3'b101);
        check_eq("dual_level_e5", btn_level, 3'b101);

        // Press ch1, reset mid-ARMING while ch0/ch2 sit in PRESSED.
        btn_raw = 3'b000;
        tick_count(4, 3'b010, pulses);
        check_eq("arming_no_pulse", pulses, 0);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_level", btn_level, 3'b000);
        check_eq("async_rst_pulse", press_pulse, 3'b000);
        btn_raw = 3'b101;
        tick_count(3, 3'b111, pulses);
        check_eq("async_rst_held_pulse", pulses, 0);
        rst_n = 1'b1;
        tick_count(5, 3'b111, pulses);
        check_eq("post_rst_no_early_pulse", pulses, 0);
        tick();
        check_eq("post_rst_pulse_e5", press_pulse, 3'b010);
        check_eq("post_rst_level_e5", btn_level, 3'b010);
        tick();
        check_eq("post_rst_pulse_e6", press_pulse, 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
